step_motion_ctrl: RTL

Motion sequencer for a 4-phase unipolar stepper driver. Accepts move commands (step count, direction, step period) over a valid/ready handshake. Generates timed steps and walks the full-step phase table forward or reverse, tracking absolute position. Sits between the system command source and the motor coil outputs A_phase..D_phase.

---
 rtl/step_motion_ctrl_if.sv | 31 +++
 rtl/step_motion_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/step_motion_ctrl_if.sv
// Command channel for step_motion_ctrl: a move request (step count, direction,
// step period) offered with valid/ready. The master drives the request and the
// controller (slave) answers with ready.
interface step_motion_ctrl_if #(
  parameter int unsigned STEP_W = 16,
  parameter int unsigned PER_W  = 24
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_dir;
  logic [PER_W-1:0]  cmd_period;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_dir,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_dir,
    input  cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/step_motion_ctrl.sv
// Motion sequencer for a 4-phase unipolar stepper. Accepts move commands over
// the step_motion_ctrl_if slave modport, emits one full step every eff_period
// clocks, walks the phase table forward or reverse and tracks signed position.
// Optional build macro COIL_IDLE_OFF_EN: releases the coils (ABCD = 0000) after
// IDLE_OFF_CYCLES consecutive idle cycles; the next accepted command restores them.
module step_motion_ctrl #(
  parameter int unsigned STEP_W     = 16,
  parameter int unsigned PER_W      = 24,
  parameter int unsigned MIN_PERIOD = 2
`ifdef COIL_IDLE_OFF_EN
  ,
  parameter int unsigned IDLE_OFF_CYCLES = 1000000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  step_motion_ctrl_if.slave cmd,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] position,
  output logic              A_phase,
  output logic              B_phase,
  output logic              C_phase,
  output logic              D_phase
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [PER_W-1:0]  MinPer  = PER_W'(MIN_PERIOD);
  localparam logic [STEP_W-1:0] OneStep = STEP_W'(1);

`ifdef COIL_IDLE_OFF_EN
  localparam int unsigned IdleW = (IDLE_OFF_CYCLES > 1) ? $clog2(IDLE_OFF_CYCLES) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_OFF_CYCLES - 1);
`endif

  // Full-step table, index -> {A,B,C,D}.
  function automatic logic [3:0] phase_lut(input logic [1:0] idx);
    logic [3:0] abcd;
    unique case (idx)
      2'd0: abcd = 4'b0110;
      2'd1: abcd = 4'b0101;
      2'd2: abcd = 4'b1001;
      2'd3: abcd = 4'b1010;
    endcase
    return abcd;
  endfunction

  state_e            state_q;
  logic [1:0]        idx_q;
  logic [STEP_W-1:0] pos_q;
  logic [STEP_W-1:0] remaining_q;
  logic [PER_W-1:0]  timer_q;
  logic [PER_W-1:0]  period_q;
  logic              dir_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic              ready_q;
  logic [3:0]        abcd_q;
`ifdef COIL_IDLE_OFF_EN
  logic [IdleW-1:0]  idle_cnt_q;
`endif

  logic [PER_W-1:0]  eff_period;
  logic [1:0]        idx_step;
  logic [STEP_W-1:0] pos_step;
  logic              accept;
  logic              step_due;

  // Clamp the requested period and precompute the next index/position for a step.
  always_comb begin
    eff_period = (cmd.cmd_period < MinPer) ? MinPer : cmd.cmd_period;
    idx_step   = dir_q ? (idx_q + 2'd1) : (idx_q - 2'd1);
    pos_step   = dir_q ? (pos_q + OneStep) : (pos_q - OneStep);
    accept     = cmd.cmd_valid & ready_q;
    step_due   = (timer_q == (period_q - PER_W'(1)));
  end

  // Move FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= 2'd0;
      pos_q       <= '0;
      remaining_q <= '0;
      timer_q     <= '0;
      period_q    <= MinPer;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      ready_q     <= 1'b1;
      abcd_q      <= 4'b0110;
`ifdef COIL_IDLE_OFF_EN
      idle_cnt_q  <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            dir_q    <= cmd.cmd_dir;
            period_q <= eff_period;
`ifdef COIL_IDLE_OFF_EN
            idle_cnt_q <= '0;
            abcd_q     <= phase_lut(idx_q);
`endif
            if (cmd.cmd_steps == '0) begin
              // Empty move completes at once without touching the coils.
              done_q <= 1'b1;
            end else begin
              state_q     <= StRun;
              busy_q      <= 1'b1;
              ready_q     <= 1'b0;
              timer_q     <= '0;
              remaining_q <= cmd.cmd_steps;
            end
          end
`ifdef COIL_IDLE_OFF_EN
          else if (idle_cnt_q == IdleLast) begin
            abcd_q <= 4'b0000;
          end else begin
            idle_cnt_q <= idle_cnt_q + IdleW'(1);
          end
`endif
        end
        StRun: begin
`ifdef COIL_IDLE_OFF_EN
          idle_cnt_q <= '0;
`endif
          if (stop) begin
            // Abort wins over a step falling due in the same cycle.
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            timer_q   <= '0;
          end else if (step_due) begin
            idx_q       <= idx_step;
            abcd_q      <= phase_lut(idx_step);
            pos_q       <= pos_step;
            remaining_q <= remaining_q - OneStep;
            timer_q     <= '0;
            if (remaining_q == OneStep) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + PER_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign position      = pos_q;
  assign {A_phase, B_phase, C_phase, D_phase} = abcd_q;

endmodule
